// File: rtl/usart_cfg_pkg.sv
// Shared definitions for the USART clock-configuration controller:
// register addresses, CTRL/MODE bit positions, FSM state encoding and
// the packed mode-bit record passed between the register file and the top.
package usart_cfg_pkg;

    localparam logic [1:0] ADDR_UBRRL = 2'd0;
    localparam logic [1:0] ADDR_UBRRH = 2'd1;
    localparam logic [1:0] ADDR_CTRL  = 2'd2;
    localparam logic [1:0] ADDR_MODE  = 2'd3;

    localparam int unsigned CTRL_TXEN_BIT  = 3;
    localparam int unsigned CTRL_RXEN_BIT  = 4;
    localparam int unsigned CTRL_BUSY_BIT  = 6;
    localparam int unsigned CTRL_ABORT_BIT = 7;

    localparam int unsigned MODE_UCPOL_BIT   = 0;
    localparam int unsigned MODE_U2X_BIT     = 1;
    localparam int unsigned MODE_DDR_XCK_BIT = 2;
    localparam int unsigned MODE_UMSEL_BIT   = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_APPLY  = 2'd2,
        ST_SETTLE = 2'd3
    } cfg_state_e;

    typedef struct packed {
        logic umsel;
        logic ddr_xck;
        logic u2x;
        logic ucpol;
    } mode_t;

endpackage

// File: rtl/usart_clk_cfg_ctrl_if.sv
// Host register bus of the USART clock-configuration controller.
//   i_wr_en  : single-cycle write strobe
//   i_addr   : register select (UBRRL, UBRRH, CTRL, MODE)
//   i_wdata  : write data
//   o_rdata  : combinational readback of the addressed register
interface usart_clk_cfg_ctrl_if;

    logic       i_wr_en;
    logic [1:0] i_addr;
    logic [7:0] i_wdata;
    logic [7:0] o_rdata;

    modport master (output i_wr_en, output i_addr, output i_wdata, input o_rdata);
    modport slave  (input i_wr_en, input i_addr, input i_wdata, output o_rdata);

endinterface

// File: rtl/usart_cfg_regfile.sv
// Host-side register file: address decode, UBRRH temp register, shadow
// divisor/enable/mode registers, readback mux and the update-request flag.
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   bus              : host register bus (slave side)
//   i_cfg_busy       : FSM-not-idle flag, reflected in CTRL readback
//   i_cfg_abort      : sticky drain-timeout flag, reflected in CTRL readback
//   i_req_clr        : request clear from the commit step
//   o_shadow_ubrr    : shadow divisor
//   o_shadow_mode    : shadow mode bits
//   o_txen_src/o_rxen_src : shadow enables including a CTRL write this cycle
//   o_req, o_req_set : pending request, and a request being raised this cycle
//   o_abort_clr      : CTRL write-1-to-clear of the abort flag
module usart_cfg_regfile
    import usart_cfg_pkg::*;
(
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    usart_clk_cfg_ctrl_if.slave        bus,
    input  logic                       i_cfg_busy,
    input  logic                       i_cfg_abort,
    input  logic                       i_req_clr,
    output logic [11:0]                o_shadow_ubrr,
    output mode_t                      o_shadow_mode,
    output logic                       o_txen_src,
    output logic                       o_rxen_src,
    output logic                       o_req,
    output logic                       o_req_set,
    output logic                       o_abort_clr
);

    logic [3:0]  r_ubrr_tmp;
    logic [11:0] r_shadow_ubrr;
    logic        r_txen;
    logic        r_rxen;
    mode_t       r_mode;
    logic        r_req;

    logic w_wr_ubrrl, w_wr_ubrrh, w_wr_ctrl, w_wr_mode;
    logic w_unused_wdata5;

    assign w_wr_ubrrl = bus.i_wr_en && (bus.i_addr == ADDR_UBRRL);
    assign w_wr_ubrrh = bus.i_wr_en && (bus.i_addr == ADDR_UBRRH);
    assign w_wr_ctrl  = bus.i_wr_en && (bus.i_addr == ADDR_CTRL);
    assign w_wr_mode  = bus.i_wr_en && (bus.i_addr == ADDR_MODE);
    assign w_unused_wdata5 = bus.i_wdata[5];

    assign o_req_set   = w_wr_ubrrl || w_wr_mode;
    assign o_abort_clr = w_wr_ctrl && bus.i_wdata[CTRL_ABORT_BIT];

    // Enables as they will stand after this cycle, so a CTRL write in the
    // same cycle as an enable load is not lost.
    assign o_txen_src = w_wr_ctrl ? bus.i_wdata[CTRL_TXEN_BIT] : r_txen;
    assign o_rxen_src = w_wr_ctrl ? bus.i_wdata[CTRL_RXEN_BIT] : r_rxen;

    assign o_shadow_ubrr = r_shadow_ubrr;
    assign o_shadow_mode = r_mode;
    assign o_req         = r_req;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ubrr_tmp    <= '0;
            r_shadow_ubrr <= '0;
            r_txen        <= 1'b0;
            r_rxen        <= 1'b0;
            r_mode        <= '0;
            r_req         <= 1'b0;
        end else begin
            if (w_wr_ubrrh) r_ubrr_tmp <= bus.i_wdata[3:0];
            if (w_wr_ubrrl) r_shadow_ubrr <= {r_ubrr_tmp, bus.i_wdata};
            if (w_wr_ctrl) begin
                r_txen <= bus.i_wdata[CTRL_TXEN_BIT];
                r_rxen <= bus.i_wdata[CTRL_RXEN_BIT];
            end
            if (w_wr_mode) begin
                r_mode.umsel   <= bus.i_wdata[MODE_UMSEL_BIT];
                r_mode.ddr_xck <= bus.i_wdata[MODE_DDR_XCK_BIT];
                r_mode.u2x     <= bus.i_wdata[MODE_U2X_BIT];
                r_mode.ucpol   <= bus.i_wdata[MODE_UCPOL_BIT];
            end
            // A new request outranks the clear issued by the commit step.
            if (o_req_set)      r_req <= 1'b1;
            else if (i_req_clr) r_req <= 1'b0;
        end
    end

    always_comb begin
        bus.o_rdata = '0;
        case (bus.i_addr)
            ADDR_UBRRL: bus.o_rdata = r_shadow_ubrr[7:0];
            ADDR_UBRRH: bus.o_rdata = {4'h0, r_shadow_ubrr[11:8]};
            ADDR_CTRL: begin
                bus.o_rdata[CTRL_TXEN_BIT]  = r_txen;
                bus.o_rdata[CTRL_RXEN_BIT]  = r_rxen;
                bus.o_rdata[CTRL_BUSY_BIT]  = i_cfg_busy;
                bus.o_rdata[CTRL_ABORT_BIT] = i_cfg_abort;
            end
            ADDR_MODE: begin
                bus.o_rdata[MODE_UMSEL_BIT]   = r_mode.umsel;
                bus.o_rdata[MODE_DDR_XCK_BIT] = r_mode.ddr_xck;
                bus.o_rdata[MODE_U2X_BIT]     = r_mode.u2x;
                bus.o_rdata[MODE_UCPOL_BIT]   = r_mode.ucpol;
            end
        endcase
    end

endmodule

// File: rtl/usart_clk_cfg_ctrl.sv
// USART baud/clock-mode configuration controller. Host writes land in
// shadow registers; an FSM waits for TX/RX to drain (bounded by a timeout),
// commits the shadow values with a one-cycle reload pulse, then holds the
// TX/RX enables low for a settle window before restoring them.
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   bus                   : host register bus (slave side)
//   i_tx_busy, i_rx_busy  : transmitter / receiver activity
//   o_ubrr, o_ubrrl_new   : active divisor and reload pulse
//   o_umsel..o_ddr_xck    : active mode bits
//   o_txen, o_rxen        : gated enables
//   o_cfg_busy            : FSM not idle
//   o_cfg_abort           : sticky drain-timeout flag
module usart_clk_cfg_ctrl
    import usart_cfg_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned DRAIN_TIMEOUT = 4096
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    usart_clk_cfg_ctrl_if.slave bus,
    input  logic                i_tx_busy,
    input  logic                i_rx_busy,
    output logic [11:0]         o_ubrr,
    output logic                o_ubrrl_new,
    output logic                o_umsel,
    output logic                o_ucpol,
    output logic                o_u2x,
    output logic                o_ddr_xck,
    output logic                o_txen,
    output logic                o_rxen,
    output logic                o_cfg_busy,
    output logic                o_cfg_abort
);

    localparam logic [15:0] DRAIN_LAST  = 16'(DRAIN_TIMEOUT - 1);
    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    cfg_state_e  r_state, w_next;
    logic [15:0] r_drain_cnt;
    logic [7:0]  r_settle_cnt;

    logic [11:0] w_shadow_ubrr;
    mode_t       w_shadow_mode;
    logic        w_txen_src, w_rxen_src;
    logic        w_req, w_req_set, w_abort_clr, w_abort_set, w_req_any;

    usart_cfg_regfile u_regfile (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .bus           (bus),
        .i_cfg_busy    (o_cfg_busy),
        .i_cfg_abort   (o_cfg_abort),
        .i_req_clr     (r_state == ST_APPLY),
        .o_shadow_ubrr (w_shadow_ubrr),
        .o_shadow_mode (w_shadow_mode),
        .o_txen_src    (w_txen_src),
        .o_rxen_src    (w_rxen_src),
        .o_req         (w_req),
        .o_req_set     (w_req_set),
        .o_abort_clr   (w_abort_clr)
    );

    // A request raised this very cycle counts, so a write in IDLE puts the
    // FSM in DRAIN on the same edge that latches the request.
    assign w_req_any = w_req || w_req_set;

    always_comb begin
        w_next      = r_state;
        w_abort_set = 1'b0;
        case (r_state)
            ST_IDLE:  if (w_req_any) w_next = ST_DRAIN;
            ST_DRAIN: begin
                if (!i_tx_busy && !i_rx_busy) begin
                    w_next = ST_APPLY;
                end else if (r_drain_cnt == DRAIN_LAST) begin
                    w_next      = ST_APPLY;
                    w_abort_set = 1'b1;
                end
            end
            ST_APPLY:  w_next = ST_SETTLE;
            ST_SETTLE: if (r_settle_cnt == SETTLE_LAST) w_next = w_req_any ? ST_DRAIN : ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_drain_cnt  <= '0;
            r_settle_cnt <= '0;
            o_ubrr       <= '0;
            o_ubrrl_new  <= 1'b0;
            o_umsel      <= 1'b0;
            o_ucpol      <= 1'b0;
            o_u2x        <= 1'b0;
            o_ddr_xck    <= 1'b0;
            o_txen       <= 1'b0;
            o_rxen       <= 1'b0;
            o_cfg_busy   <= 1'b0;
            o_cfg_abort  <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_drain_cnt  <= (r_state == ST_DRAIN)  ? r_drain_cnt + 16'd1 : '0;
            r_settle_cnt <= (r_state == ST_SETTLE) ? r_settle_cnt + 8'd1 : '0;
            o_ubrrl_new  <= (w_next == ST_APPLY);
            o_cfg_busy   <= (w_next != ST_IDLE);

            if (r_state == ST_APPLY) begin
                o_ubrr    <= w_shadow_ubrr;
                o_umsel   <= w_shadow_mode.umsel;
                o_ucpol   <= w_shadow_mode.ucpol;
                o_u2x     <= w_shadow_mode.u2x;
                o_ddr_xck <= w_shadow_mode.ddr_xck;
            end

            // Enables: forced low through APPLY/SETTLE, reloaded on SETTLE
            // exit, tracking shadow while idle, frozen during DRAIN.
            if (w_next == ST_APPLY || w_next == ST_SETTLE) begin
                o_txen <= 1'b0;
                o_rxen <= 1'b0;
            end else if ((r_state == ST_IDLE && w_next == ST_IDLE) || r_state == ST_SETTLE) begin
                o_txen <= w_txen_src;
                o_rxen <= w_rxen_src;
            end

            if (w_abort_set)      o_cfg_abort <= 1'b1;
            else if (w_abort_clr) o_cfg_abort <= 1'b0;
        end
    end

endmodule

// File: tb/tb_usart_clk_cfg_ctrl.sv
module tb_usart_clk_cfg_ctrl;

    localparam int SETTLE = 4;
    localparam int TMO    = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        tx_busy = 1'b0, rx_busy = 1'b0;
    logic [11:0] o_ubrr;
    logic        o_ubrrl_new, o_umsel, o_ucpol, o_u2x, o_ddr_xck;
    logic        o_txen, o_rxen, o_cfg_busy, o_cfg_abort;

    always #5 clk = ~clk;

    usart_clk_cfg_ctrl_if bus_if ();

    usart_clk_cfg_ctrl #(.SETTLE_CYCLES(SETTLE), .DRAIN_TIMEOUT(TMO)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus_if),
        .i_tx_busy(tx_busy), .i_rx_busy(rx_busy),
        .o_ubrr(o_ubrr), .o_ubrrl_new(o_ubrrl_new),
        .o_umsel(o_umsel), .o_ucpol(o_ucpol), .o_u2x(o_u2x), .o_ddr_xck(o_ddr_xck),
        .o_txen(o_txen), .o_rxen(o_rxen), .o_cfg_busy(o_cfg_busy), .o_cfg_abort(o_cfg_abort)
    );

    int n_checks = 0, n_errors = 0, cyc = 0, last_pulse = -1;
    logic b_tx = 1'b0, b_rx = 1'b0;

    // Behavioural reference: shadow state, pending request, and a commit
    // timeline tracked as a drain age, an apply flag and settle cycles left.
    logic [3:0]  m_tmp;
    logic [11:0] m_sh_ubrr;
    logic        m_sh_tx, m_sh_rx, m_req, m_active, m_apply;
    logic [7:0]  m_sh_mode;
    int          m_drain, m_settle;
    logic [11:0] e_ubrr;
    logic [7:0]  e_mode;
    logic        e_tx, e_rx, e_new, e_abort;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_tmp = '0; m_sh_ubrr = '0; m_sh_tx = 0; m_sh_rx = 0; m_sh_mode = '0;
        m_req = 0; m_active = 0; m_apply = 0; m_drain = -1; m_settle = 0;
        e_ubrr = '0; e_mode = '0; e_tx = 0; e_rx = 0; e_new = 0; e_abort = 0;
        last_pulse = -1;
    endtask

    function automatic logic [7:0] exp_rdata(input logic [1:0] a);
        case (a)
            2'd0:    return m_sh_ubrr[7:0];
            2'd1:    return {4'h0, m_sh_ubrr[11:8]};
            2'd2:    return {e_abort, m_active, 1'b0, m_sh_rx, m_sh_tx, 3'b000};
            default: return m_sh_mode;
        endcase
    endfunction

    // Advance the reference by one clock using the inputs currently driven.
    task automatic model_step();
        logic       wr, req_set, ctrl_wr, src_tx, src_rx, abort_set, was_apply, req_now;
        logic [1:0] a;
        logic [7:0] d;
        wr = bus_if.i_wr_en; a = bus_if.i_addr; d = bus_if.i_wdata;
        req_set = wr && (a == 2'd0 || a == 2'd3);
        ctrl_wr = wr && (a == 2'd2);
        src_tx = ctrl_wr ? d[3] : m_sh_tx;
        src_rx = ctrl_wr ? d[4] : m_sh_rx;
        req_now = m_req || req_set;
        abort_set = 0;
        was_apply = m_apply;
        e_new = 0;
        if (m_apply) begin
            e_ubrr = m_sh_ubrr; e_mode = m_sh_mode;
            m_apply = 0; m_settle = SETTLE;
        end else if (m_settle > 0) begin
            m_settle--;
            if (m_settle == 0) begin
                e_tx = src_tx; e_rx = src_rx;
                if (req_now) m_drain = 0; else m_active = 0;
            end
        end else if (m_drain >= 0) begin
            if ((!b_tx && !b_rx) || m_drain == TMO - 1) begin
                abort_set = b_tx || b_rx;
                m_drain = -1; m_apply = 1; e_new = 1; e_tx = 0; e_rx = 0;
            end else begin
                m_drain++;
            end
        end else if (req_now) begin
            m_active = 1; m_drain = 0;
        end else begin
            e_tx = src_tx; e_rx = src_rx;
        end
        if (req_set) m_req = 1; else if (was_apply) m_req = 0;
        if (abort_set) e_abort = 1; else if (ctrl_wr && d[7]) e_abort = 0;
        if (wr) begin
            case (a)
                2'd0: m_sh_ubrr = {m_tmp, d};
                2'd1: m_tmp = d[3:0];
                2'd2: begin m_sh_tx = d[3]; m_sh_rx = d[4]; end
                default: m_sh_mode = d & 8'h47;
            endcase
        end
    endtask

    task automatic check_outputs();
        chk("ubrr", 32'(o_ubrr), 32'(e_ubrr));
        chk("reload_pulse", 32'(o_ubrrl_new), 32'(e_new));
        chk("mode", 32'({o_umsel, o_ddr_xck, o_u2x, o_ucpol}), 32'({e_mode[6], e_mode[2], e_mode[1], e_mode[0]}));
        chk("enables", 32'({o_txen, o_rxen}), 32'({e_tx, e_rx}));
        chk("cfg_busy", 32'(o_cfg_busy), 32'(m_active));
        chk("cfg_abort", 32'(o_cfg_abort), 32'(e_abort));
        if (o_ubrrl_new) begin
            if (last_pulse >= 0) chk("pulse_gap_ok", 32'(cyc - last_pulse >= SETTLE + 2), 32'd1);
            last_pulse = cyc;
        end
    endtask

    task automatic cycle(input logic wr, input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        cyc++;
        check_outputs();
        bus_if.i_wr_en = wr; bus_if.i_addr = a; bus_if.i_wdata = d;
        tx_busy = b_tx; rx_busy = b_rx;
        #1;
        chk("rdata", 32'(bus_if.o_rdata), 32'(exp_rdata(a)));
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 8'h00);
    endtask

    task automatic do_reset(input bit pre_check);
        if (pre_check) begin
            @(negedge clk);
            check_outputs();
        end
        rst_n = 1'b0;
        bus_if.i_wr_en = 0; bus_if.i_addr = 2'd0; bus_if.i_wdata = 8'h00;
        b_tx = 0; b_rx = 0; tx_busy = 0; rx_busy = 0;
        #1;
        chk("rst_ubrr", 32'(o_ubrr), 32'd0);
        chk("rst_flags", 32'({o_ubrrl_new, o_umsel, o_ucpol, o_u2x, o_ddr_xck, o_txen, o_rxen, o_cfg_busy, o_cfg_abort}), 32'd0);
        chk("rst_rdata", 32'(bus_if.o_rdata), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_step();
    endtask

    task automatic wait_settle();
        for (int k = 0; k < 40 && m_settle == 0; k++) idle(1);
        chk("in_settle_busy", 32'(o_cfg_busy), 32'd1);
    endtask

    initial begin
        bus_if.i_wr_en = 0; bus_if.i_addr = 2'd0; bus_if.i_wdata = 8'h00;
        #2;
        do_reset(1'b0);

        // Basic commit
        cycle(1, 2'd1, 8'h01);
        cycle(1, 2'd0, 8'h23);
        idle(12);
        chk("basic_ubrr", 32'(o_ubrr), 32'h123);

        // Drain wait on transmitter
        b_tx = 1; idle(10);
        cycle(1, 2'd3, 8'h41);
        idle(8);
        chk("drain_hold_umsel", 32'(o_umsel), 32'd0);
        b_tx = 0; idle(10);
        chk("drain_umsel_ucpol", 32'({o_umsel, o_ucpol}), 32'h3);
        chk("drain_no_abort", 32'(o_cfg_abort), 32'd0);

        // Drain timeout on receiver, then write-1-to-clear
        b_rx = 1;
        cycle(1, 2'd1, 8'h00);
        cycle(1, 2'd0, 8'h10);
        idle(25);
        chk("timeout_abort", 32'(o_cfg_abort), 32'd1);
        chk("timeout_ubrr", 32'(o_ubrr), 32'h010);
        cycle(1, 2'd2, 8'h80);
        idle(1);
        chk("abort_cleared", 32'(o_cfg_abort), 32'd0);
        b_rx = 0; idle(3);

        // Write during SETTLE triggers a second commit
        cycle(1, 2'd0, 8'h07);
        wait_settle();
        cycle(1, 2'd0, 8'h05);
        idle(25);
        chk("settle_rewrite_ubrr", 32'(o_ubrr), 32'h005);

        // CTRL-only write in IDLE
        cycle(1, 2'd2, 8'h18);
        @(posedge clk); #1;
        chk("ctrl_idle_en", 32'({o_txen, o_rxen}), 32'h3);
        chk("ctrl_idle_nopulse", 32'(o_ubrrl_new), 32'd0);
        chk("ctrl_idle_busy", 32'(o_cfg_busy), 32'd0);
        idle(2);

        // Reset in SETTLE
        cycle(1, 2'd0, 8'h33);
        wait_settle();
        do_reset(1'b1);
        idle(3);

        // Randomized traffic against the reference
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 499) == 0) do_reset(1'b1);
            if ($urandom_range(0, 9) == 0) b_tx = ~b_tx;
            if ($urandom_range(0, 11) == 0) b_rx = ~b_rx;
            if ($urandom_range(0, 4) == 0)
                cycle(1'b1, 2'($urandom_range(0, 3)), 8'($urandom));
            else
                cycle(1'b0, 2'($urandom_range(0, 3)), 8'($urandom));
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
